display_value_counter: RTL and testbench

DISPLAY_VALUE_COUNTER -- requirements
Module: display_value_counter

---
 rtl/display_pkg.sv | 43 ++++
 rtl/key_debounce.sv | 44 ++++
 rtl/display_value_counter.sv | 93 +++++++++
 tb/tb_display_value_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared key indices, event priority encoding and timing derivations for the
// display value counter.
package display_pkg;

  localparam int KEY_CLR  = 0;
  localparam int KEY_LOAD = 1;
  localparam int KEY_INC  = 2;
  localparam int KEY_DEC  = 3;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLR,
    EV_LOAD,
    EV_INC,
    EV_DEC,
    EV_AUTO
  } event_t;

  function automatic int db_cycles(input int clk_hz, input int debounce_ms);
    int c;
    c = clk_hz / 1000 * debounce_ms;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int auto_div(input int clk_hz, input int auto_hz);
    int d;
    d = clk_hz / auto_hz;
    return (d < 1) ? 1 : d;
  endfunction

  // Highest-priority event wins; hold only masks the counting events.
  function automatic event_t pick_event(input logic [3:0] press, input logic tick,
                                        input logic hold);
    if (press[KEY_CLR])  return EV_CLR;
    if (press[KEY_LOAD]) return EV_LOAD;
    if (hold)            return EV_NONE;
    if (press[KEY_INC])  return EV_INC;
    if (press[KEY_DEC])  return EV_DEC;
    if (tick)            return EV_AUTO;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-flop synchronizer, stable-time debouncer and a
// registered one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= 1'b0;
      // Any cycle where the input agrees with the debounced state restarts the count.
      if (sync_b == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_b;
        cnt    <= '0;
        press  <= ~sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_value_counter.sv
// Byte counter driven by debounced keys and an auto-increment prescaler; feeds
// a seven-segment stage with VALUE plus a change pulse, mirrored on LEDR.
module display_value_counter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int AUTO_HZ     = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [7:0] VALUE,
  output logic       UPDATE,
  output logic [9:0] LEDR
);

  import display_pkg::*;

  localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int AUTO_DIV  = auto_div(CLK_HZ, AUTO_HZ);
  localparam int PW        = $clog2(AUTO_DIV + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(AUTO_DIV - 1);

  logic [3:0]    press;
  logic [PW-1:0] prescale;
  logic          tick;
  event_t        ev;
  logic [7:0]    value_nxt;
  logic          wrap_nxt;
  logic          wrap_q;
  logic          auto_q;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .raw   (KEY[i]),
      .press (press[i])
    );
  end

  // Held at zero while disabled so the first tick lands a full period after enable.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)              prescale <= '0;
    else if (!SW[9])           prescale <= '0;
    else if (prescale == PRE_LAST) prescale <= '0;
    else                       prescale <= prescale + 1'b1;
  end

  assign tick = SW[9] && (prescale == PRE_LAST);

  always_comb begin
    ev        = pick_event(press, tick, SW[8]);
    value_nxt = VALUE;
    wrap_nxt  = wrap_q;
    case (ev)
      EV_CLR: begin
        value_nxt = 8'h00;
        wrap_nxt  = 1'b0;
      end
      EV_LOAD: begin
        value_nxt = SW[7:0];
        wrap_nxt  = 1'b0;
      end
      EV_INC, EV_AUTO: begin
        value_nxt = VALUE + 1'b1;
        if (VALUE == 8'hFF) wrap_nxt = 1'b1;
      end
      EV_DEC: begin
        value_nxt = VALUE - 1'b1;
        if (VALUE == 8'h00) wrap_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      VALUE  <= 8'h00;
      UPDATE <= 1'b0;
      wrap_q <= 1'b0;
      auto_q <= 1'b0;
    end else begin
      VALUE  <= value_nxt;
      UPDATE <= (value_nxt != VALUE);
      wrap_q <= wrap_nxt;
      auto_q <= SW[9];
    end
  end

  assign LEDR = {wrap_q, auto_q, VALUE};

endmodule

// File: tb/tb_display_value_counter.sv
// Bench for display_value_counter at DB_CYCLES=3, auto period 10: expected
// VALUE/wrap pushed on each event-producing stimulus, popped on every UPDATE.
module tb_display_value_counter;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [9:0] sw;
  logic [7:0] value;
  logic       update;
  logic [9:0] ledr;

  typedef struct {
    logic [7:0] value;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   upd_cnt  = 0;
  int   last_upd = -1;

  display_value_counter #(
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (3),
    .AUTO_HZ     (100)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY      (key),
    .SW       (sw),
    .VALUE    (value),
    .UPDATE   (update),
    .LEDR     (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every UPDATE pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && update) begin
      upd_cnt++;
      last_upd = cyc;
      if (exp_q.size() == 0) begin
        chk("pending_expect", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("update_value", {24'b0, value}, {24'b0, e.value});
        chk("update_wrap", {31'b0, ledr[9]}, {31'b0, e.wrap});
        chk("ledr_mirror", {24'b0, ledr[7:0]}, {24'b0, e.value});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input logic w);
    exp_t e;
    e.value = v;
    e.wrap  = w;
    exp_q.push_back(e);
  endtask

  // Hold the masked keys low, then release and let the release debounce settle.
  task automatic press(input logic [3:0] mask, input int low_cyc);
    key = ~mask;
    repeat (low_cyc) step();
    key = 4'hF;
    repeat (8) step();
  endtask

  initial begin
    int c0;
    int u0;
    rst_n = 1'b0;
    key   = 4'hF;
    sw    = 10'h000;
    repeat (3) step();
    chk("reset_value", {24'b0, value}, 32'h00);
    chk("reset_update", {31'b0, update}, 32'h0);
    chk("reset_ledr", {22'b0, ledr}, 32'h000);
    rst_n = 1'b1;
    repeat (3) step();

    // Load A5: VALUE changes 2 sync + 3 debounce + 1 cycles after the raw edge.
    sw = 10'h0A5;
    u0 = upd_cnt;
    c0 = cyc;
    push(8'hA5, 1'b0);
    press(4'b0010, 10);
    chk("load_latency", last_upd - c0, 6);
    chk("load_one_pulse", upd_cnt - u0, 1);

    // Bouncing increment: 0,1 glitch then a solid low gives a single event.
    u0 = upd_cnt;
    push(8'hA6, 1'b0);
    key = 4'b1011; step();
    key = 4'b1111; step();
    press(4'b0100, 10);
    chk("bounce_one_inc", upd_cnt - u0, 1);
    chk("bounce_value", {24'b0, value}, 32'hA6);

    // FF + 1 wraps to 00 and sets the sticky flag.
    sw = 10'h0FF;
    push(8'hFF, 1'b0);
    press(4'b0010, 10);
    push(8'h00, 1'b1);
    press(4'b0100, 10);
    chk("wrap_flag_set", {31'b0, ledr[9]}, 32'h1);

    // Loading the current value: flag cleared, no UPDATE pulse.
    sw = 10'h000;
    u0 = upd_cnt;
    press(4'b0010, 10);
    chk("same_load_no_pulse", upd_cnt - u0, 0);
    chk("same_load_wrap_clr", {31'b0, ledr[9]}, 32'h0);
    chk("same_load_value", {24'b0, value}, 32'h00);

    // Same-cycle increment and decrement: increment wins.
    sw = 10'h010;
    push(8'h10, 1'b0);
    press(4'b0010, 10);
    push(8'h11, 1'b0);
    press(4'b1100, 10);
    chk("inc_over_dec", {24'b0, value}, 32'h11);

    // Clear with load: clear wins even though SW holds a different value.
    push(8'h00, 1'b0);
    press(4'b0011, 10);
    chk("clr_over_load", {24'b0, value}, 32'h00);

    // 00 - 1 wraps to FF; clear drops the flag.
    push(8'hFF, 1'b1);
    press(4'b1000, 10);
    push(8'h00, 1'b0);
    press(4'b0001, 10);
    chk("clear_wrap_clr", {31'b0, ledr[9]}, 32'h0);

    // Auto-increment: ticks at +10, +20, +30 cycles after enable.
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    sw = 10'h200;
    repeat (2) step();
    chk("auto_led", {31'b0, ledr[8]}, 32'h1);
    repeat (33) step();
    sw = 10'h000;
    repeat (5) step();
    chk("auto_value", {24'b0, value}, 32'h03);

    // Hold blocks auto tick and increment; load still acts.
    u0 = upd_cnt;
    sw = 10'h300;
    repeat (35) step();
    sw = 10'h100;
    press(4'b0100, 10);
    chk("hold_no_change", upd_cnt - u0, 0);
    chk("hold_value", {24'b0, value}, 32'h03);
    sw = 10'h142;
    push(8'h42, 1'b0);
    press(4'b0010, 10);
    sw = 10'h000;

    // Reset mid-debounce discards the press; the held key re-debounces afterwards.
    key = 4'b1011;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_value", {24'b0, value}, 32'h00);
    chk("rst_mid_ledr", {22'b0, ledr}, 32'h000);
    repeat (3) step();
    u0 = upd_cnt;
    rst_n = 1'b1;
    c0 = cyc;
    push(8'h01, 1'b0);
    repeat (10) step();
    key = 4'hF;
    repeat (8) step();
    chk("rst_inc_latency", last_upd - c0, 6);
    chk("rst_one_inc", upd_cnt - u0, 1);

    repeat (5) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
